// File: rtl/mult_pkg.sv
// mult_pkg: saturation bound helpers and legal parameter ranges shared by the multiply-add pipe.
package mult_pkg;
  localparam int PIPE_MIN = 1;
  localparam int PIPE_MAX = 4;
  localparam int WP_MIN = 2;
  localparam int WP_MAX = 64;
  localparam int BOUND_W = 128;
  function automatic logic signed [BOUND_W-1:0] sat_hi(input int w, input bit sgn);
    return sgn ? (BOUND_W'(1) << (w - 1)) - BOUND_W'(1) : (BOUND_W'(1) << w) - BOUND_W'(1);
  endfunction
  function automatic logic signed [BOUND_W-1:0] sat_lo(input int w, input bit sgn);
    return sgn ? -(BOUND_W'(1) << (w - 1)) : '0;
  endfunction
endpackage

// File: rtl/mult_sat.sv
// mult_sat: clamps a wide signed intermediate to the WP-bit signed or unsigned range and flags overflow.
module mult_sat
  import mult_pkg::*;
#(
  parameter int IW = 42,
  parameter int WP = 24,
  parameter bit SGN = 1'b1
) (
  input  logic signed [IW-1:0] din,
  output logic        [WP-1:0] dout,
  output logic                 ovf
);
  localparam logic signed [IW-1:0] HI = IW'(sat_hi(WP, SGN));
  localparam logic signed [IW-1:0] LO = IW'(sat_lo(WP, SGN));
  logic hi_hit, lo_hit;
  always_comb begin
    hi_hit = din > HI;
    lo_hit = din < LO;
    ovf = hi_hit | lo_hit;
    dout = hi_hit ? WP'(HI) : lo_hit ? WP'(LO) : WP'(din);
  end
endmodule

// File: rtl/lpm_mult_pipe.sv
// lpm_mult_pipe: pipelined multiply-add / multiply-accumulate with saturation.
// Stage 1 registers the product, later stages delay it, the output stage adds and saturates.
module lpm_mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTHA = 8,
  parameter int WIDTHB = 8,
  parameter int WIDTHS = 16,
  parameter int WIDTHP = 24,
  parameter int SIGNED = 1,
  parameter int PIPELINE = 2
) (
  input  logic              clock,
  input  logic              aclr_n,
  input  logic              clken,
  input  logic              in_valid,
  input  logic [WIDTHA-1:0] dataa,
  input  logic [WIDTHB-1:0] datab,
  input  logic [WIDTHS-1:0] sum,
  input  logic              acc_en,
  input  logic              acc_clear,
  output logic              out_valid,
  output logic [WIDTHP-1:0] result,
  output logic              overflow
);
  localparam int PW = WIDTHA + WIDTHB + 1;
  localparam int IW = WIDTHP + WIDTHA + WIDTHB + 2;
  localparam bit SG = SIGNED != 0;
  localparam int DEPTH = PIPELINE < PIPE_MIN ? PIPE_MIN : PIPELINE > PIPE_MAX ? PIPE_MAX : PIPELINE;
  typedef struct packed {
    logic              v;
    logic              ae;
    logic              ac;
    logic [PW-1:0]     prod;
    logic [WIDTHS-1:0] sm;
  } stage_t;
  // st[0] is the combinational input stage; st[i] is the i-th register stage
  stage_t st [DEPTH];
  stage_t fin;
  logic signed [PW-1:0] a_x, b_x;
  logic signed [IW-1:0] prod_x, sum_x, acc_x, base_x, inter;
  logic [WIDTHP-1:0] sat_res, result_d, result_q, acc_d, acc_q;
  logic sat_ovf, take, out_valid_d, out_valid_q, overflow_d, overflow_q;
  always_comb begin
    a_x = SG ? PW'($signed(dataa)) : PW'(dataa);
    b_x = SG ? PW'($signed(datab)) : PW'(datab);
  end
  assign st[0] = '{v: in_valid, ae: acc_en, ac: acc_en & acc_clear, prod: a_x * b_x, sm: sum};
  for (genvar i = 1; i < DEPTH; i++) begin : g_stage
    stage_t st_d, st_q;
    always_comb st_d = clken ? st[i-1] : st_q;
    always_ff @(posedge clock or negedge aclr_n)
      if (!aclr_n) st_q <= '0;
      else st_q <= st_d;
    assign st[i] = st_q;
  end
  assign fin = st[DEPTH-1];
  always_comb begin
    prod_x = IW'($signed(fin.prod));
    sum_x = SG ? IW'($signed(fin.sm)) : IW'(fin.sm);
    acc_x = SG ? IW'($signed(acc_q)) : IW'(acc_q);
    base_x = fin.ae ? (fin.ac ? '0 : acc_x) : sum_x;
    inter = prod_x + base_x;
  end
  mult_sat #(.IW(IW), .WP(WIDTHP), .SGN(SG)) u_sat (
    .din (inter),
    .dout(sat_res),
    .ovf (sat_ovf)
  );
  // the accumulator closes its loop here so consecutive accumulating operands chain without a bubble
  always_comb begin
    take = clken & fin.v;
    out_valid_d = clken ? fin.v : out_valid_q;
    result_d = take ? sat_res : result_q;
    overflow_d = take ? sat_ovf : overflow_q;
    acc_d = (take & fin.ae) ? sat_res : acc_q;
  end
  always_ff @(posedge clock or negedge aclr_n)
    if (!aclr_n) begin
      out_valid_q <= 1'b0;
      result_q <= '0;
      overflow_q <= 1'b0;
      acc_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      overflow_q <= overflow_d;
      acc_q <= acc_d;
    end
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_lpm_mult_pipe.sv
// tb_lpm_mult_pipe: directed checks of the multiply-add pipe plus a randomized sweep of PIPELINE 1..4.
module tb_lpm_mult_pipe;
  localparam int N = 160;
  logic clk = 1'b0;
  logic aclr_n, clken, in_valid, acc_en, acc_clear;
  logic [7:0] dataa, datab;
  logic [15:0] sum;
  logic v0, o0, v1, o1;
  logic [23:0] r0;
  logic [7:0] r1;
  logic rv [1:4];
  logic ro [1:4];
  logic [11:0] rr [1:4];
  int total = 0, bad = 0;
  int idx;
  bit ev;
  longint acc_m;
  bit exp_v [N];
  bit exp_o [N];
  logic [11:0] exp_r [N];
  logic [7:0] ra, rb;
  logic [15:0] rs;
  bit rvin, rae, rac;
  bit ck [11] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  bit cv [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  logic [23:0] cr [11] = '{24'd1, 24'd2, 24'd5, 24'd5, 24'd5, 24'd5, 24'd8, 24'd11, 24'd14, 24'd17, 24'd17};
  int k;

  always #5 clk = ~clk;

  lpm_mult_pipe u0 (
    .clock(clk), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid),
    .dataa(dataa), .datab(datab), .sum(sum), .acc_en(acc_en), .acc_clear(acc_clear),
    .out_valid(v0), .result(r0), .overflow(o0)
  );
  lpm_mult_pipe #(.SIGNED(0), .WIDTHP(8)) u1 (
    .clock(clk), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid),
    .dataa(dataa), .datab(datab), .sum(sum), .acc_en(acc_en), .acc_clear(acc_clear),
    .out_valid(v1), .result(r1), .overflow(o1)
  );
  for (genvar g = 1; g <= 4; g++) begin : g_rnd
    lpm_mult_pipe #(.WIDTHP(12), .PIPELINE(g)) u (
      .clock(clk), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid),
      .dataa(dataa), .datab(datab), .sum(sum), .acc_en(acc_en), .acc_clear(acc_clear),
      .out_valid(rv[g]), .result(rr[g]), .overflow(ro[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] a, input logic [7:0] b, input logic [15:0] s,
                       input bit ae, input bit ac);
    in_valid = v;
    dataa = a;
    datab = b;
    sum = s;
    acc_en = ae;
    acc_clear = ac;
  endtask

  // signed 8x8 + 16 reference saturating to 12 bits
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic [15:0] s,
                                input bit ae, input bit ac, output logic [11:0] r, output bit ov);
    longint p, base, t;
    p = longint'($signed(a)) * longint'($signed(b));
    base = ae ? (ac ? 64'sd0 : acc_m) : longint'($signed(s));
    t = p + base;
    ov = (t > 2047) || (t < -2048);
    t = t > 2047 ? 64'sd2047 : t < -2048 ? -64'sd2048 : t;
    r = 12'(t);
    if (ae) acc_m = t;
  endfunction

  initial begin
    aclr_n = 1'b0;
    clken = 1'b1;
    drive(0, 8'd0, 8'd0, 16'd0, 0, 0);
    tick();
    tick();
    chk("rst_valid", v0, 1'b0);
    chk("rst_result", r0, 24'd0);
    chk("rst_ovf", o0, 1'b0);
    aclr_n = 1'b1;
    tick();
    drive(1, 8'hFD, 8'd5, 16'd7, 0, 0);
    tick();
    chk("madd_lat_v", v0, 1'b0);
    drive(0, 8'd0, 8'd0, 16'd0, 0, 0);
    tick();
    chk("madd_v", v0, 1'b1);
    chk("madd_r", r0, 24'hFFFFF8);
    chk("madd_ovf", o0, 1'b0);
    tick();
    chk("bubble_v", v0, 1'b0);
    chk("bubble_hold", r0, 24'hFFFFF8);
    drive(1, 8'd2, 8'd3, 16'd0, 1, 1);
    tick();
    drive(1, 8'd4, 8'd5, 16'd0, 1, 0);
    tick();
    chk("acc0_v", v0, 1'b1);
    chk("acc0_r", r0, 24'd6);
    drive(1, 8'd1, 8'd1, 16'd0, 1, 0);
    tick();
    chk("acc1_v", v0, 1'b1);
    chk("acc1_r", r0, 24'd26);
    drive(0, 8'd0, 8'd0, 16'd0, 0, 0);
    tick();
    chk("acc2_v", v0, 1'b1);
    chk("acc2_r", r0, 24'd27);
    tick();
    chk("acc_end_v", v0, 1'b0);
    chk("acc_end_hold", r0, 24'd27);
    drive(1, 8'd255, 8'd255, 16'd0, 0, 0);
    tick();
    drive(0, 8'd0, 8'd0, 16'd0, 0, 0);
    tick();
    chk("usat_v", v1, 1'b1);
    chk("usat_r", r1, 8'd255);
    chk("usat_ovf", o1, 1'b1);
    chk("neg1sq_r", r0, 24'd1);
    chk("neg1sq_ovf", o0, 1'b0);
    k = 0;
    for (int n = 0; n < 11; n++) begin
      clken = ck[n];
      if (k < 6) drive(1, 8'(k + 1), 8'd2, 16'(k), 0, 0);
      else drive(0, 8'd0, 8'd0, 16'd0, 0, 0);
      tick();
      if (ck[n] && k < 6) k++;
      chk("freeze_v", v0, cv[n]);
      chk("freeze_r", r0, cr[n]);
    end
    clken = 1'b1;
    drive(1, 8'd3, 8'd3, 16'd0, 0, 0);
    tick();
    drive(1, 8'd2, 8'd2, 16'd0, 0, 0);
    tick();
    chk("pre_rst_v", v0, 1'b1);
    chk("pre_rst_r", r0, 24'd9);
    drive(0, 8'd0, 8'd0, 16'd0, 0, 0);
    #1 aclr_n = 1'b0;
    #1;
    chk("async_rst_v", v0, 1'b0);
    chk("async_rst_r", r0, 24'd0);
    chk("async_rst_ovf", o0, 1'b0);
    tick();
    chk("rst_hold_v", v0, 1'b0);
    aclr_n = 1'b1;
    tick();
    chk("post_rst_v0", v0, 1'b0);
    tick();
    chk("post_rst_v1", v0, 1'b0);
    drive(1, 8'd1, 8'd1, 16'd0, 1, 0);
    tick();
    chk("post_rst_lat", v0, 1'b0);
    drive(0, 8'd0, 8'd0, 16'd0, 0, 0);
    tick();
    chk("post_rst_acc_v", v0, 1'b1);
    chk("post_rst_acc_r", r0, 24'd1);
    aclr_n = 1'b0;
    #1 aclr_n = 1'b1;
    acc_m = 0;
    for (int n = 0; n < N + 4; n++) begin
      if (n < N) begin
        rvin = $urandom_range(0, 9) != 0;
        ra = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'($urandom_range(0, 15)) - 8'd8;
        rb = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'($urandom_range(0, 15)) - 8'd8;
        rs = 16'($urandom_range(0, 2047)) - 16'd1024;
        rae = $urandom_range(0, 1) != 0;
        rac = $urandom_range(0, 3) == 0;
        drive(rvin, ra, rb, rs, rae, rac);
        exp_v[n] = rvin;
        if (rvin) model(ra, rb, rs, rae, rac, exp_r[n], exp_o[n]);
      end else drive(0, 8'd0, 8'd0, 16'd0, 0, 0);
      tick();
      for (int p = 1; p <= 4; p++) begin
        idx = n - p + 1;
        ev = idx >= 0 && idx < N && exp_v[idx];
        chk($sformatf("rnd_p%0d_v", p), rv[p], ev);
        if (ev) begin
          chk($sformatf("rnd_p%0d_r", p), rr[p], exp_r[idx]);
          chk($sformatf("rnd_p%0d_ovf", p), ro[p], exp_o[idx]);
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
